// File: rtl/vpu_mem_responder.sv
// Memory-side responder for the VPU operand/result interface: two read ports,
// one write port, a host preload port and a fixed, configurable read latency.
module vpu_mem_responder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 32,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_a_en,
  input  logic              rd_b_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [DATA_W-1:0] data_c,
  output logic              mem_rdy,
  output logic              mem_valid,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              err_oob
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rd_a_q, rd_b_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q;
  logic [DATA_W-1:0] data_a_q, data_b_q;
  logic              err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept, acc_wr, acc_rd, do_load, fire, oob_evt;
  logic              sel_live;
  logic              sel_a_en, sel_b_en;
  logic [ADDR_W-1:0] sel_a_addr, sel_b_addr;
  logic [DATA_W-1:0] rd_val_a, rd_val_b;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;

  function automatic logic is_oob(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= (ADDR_W+1)'(DEPTH));
  endfunction

  assign mem_rdy   = rst && (state_q == IDLE) && !load_en;
  assign mem_valid = (state_q == WRITE) || ((state_q == READ) && (cnt_q == 3'd0));
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign err_oob   = err_q;

  assign accept  = mem_rdy && (rd_a_en || rd_b_en || wr_en);
  assign acc_wr  = accept && wr_en;
  assign acc_rd  = accept && !wr_en;
  assign do_load = rst && (state_q == IDLE) && load_en;

  // Read data is captured on the edge that enters the valid cycle; with a
  // one-cycle latency that edge is the accept edge itself, so use live inputs.
  assign fire     = (acc_rd && (READ_LAT == 1)) || ((state_q == READ) && (cnt_q == 3'd1));
  assign sel_live = (state_q == IDLE);

  always_comb begin
    sel_a_en   = sel_live ? rd_a_en : rd_a_q;
    sel_b_en   = sel_live ? rd_b_en : rd_b_q;
    sel_a_addr = sel_live ? addr_a  : addr_a_q;
    sel_b_addr = sel_live ? addr_b  : addr_b_q;
    rd_val_a   = is_oob(sel_a_addr) ? '0 : mem_q[sel_a_addr[IDX_W-1:0]];
    rd_val_b   = is_oob(sel_b_addr) ? '0 : mem_q[sel_b_addr[IDX_W-1:0]];
  end

  always_comb begin
    oob_evt = (acc_wr && is_oob(addr_c))
           || (acc_rd && ((rd_a_en && is_oob(addr_a)) || (rd_b_en && is_oob(addr_b))))
           || (do_load && is_oob(load_addr));
    mem_we    = (acc_wr && !is_oob(addr_c)) || (do_load && !is_oob(load_addr));
    mem_widx  = acc_wr ? addr_c[IDX_W-1:0] : load_addr[IDX_W-1:0];
    mem_wdata = acc_wr ? data_c : load_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (acc_wr) begin
          state_d = WRITE;
        end else if (acc_rd) begin
          state_d = READ;
          cnt_d   = 3'(READ_LAT - 1);
        end
      end
      READ: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_a_q   <= 1'b0;
      rd_b_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc_rd) begin
        rd_a_q   <= rd_a_en;
        rd_b_q   <= rd_b_en;
        addr_a_q <= addr_a;
        addr_b_q <= addr_b;
      end
      if (fire && sel_a_en) data_a_q <= rd_val_a;
      if (fire && sel_b_en) data_b_q <= rd_val_b;
      if (oob_evt)          err_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_vpu_mem_responder.sv
// Directed bench for vpu_mem_responder (default parameters, READ_LAT=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_vpu_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_a_en, rd_b_en, wr_en;
  logic [15:0] addr_a, addr_b, addr_c;
  logic [31:0] data_c;
  logic        mem_rdy, mem_valid;
  logic [31:0] data_a, data_b;
  logic        load_en;
  logic [15:0] load_addr;
  logic [31:0] load_data;
  logic        err_oob;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vpu_mem_responder dut (
    .clk(clk), .rst(rst),
    .rd_a_en(rd_a_en), .rd_b_en(rd_b_en), .wr_en(wr_en),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .data_c(data_c),
    .mem_rdy(mem_rdy), .mem_valid(mem_valid),
    .data_a(data_a), .data_b(data_b),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .err_oob(err_oob)
  );

  // Read accepted at edge T; checks cycles T+1, T+2 (valid) and T+3.
  task automatic do_read(input string nm, input logic ea, input logic eb,
                         input logic [15:0] aa, input logic [15:0] ab,
                         input logic [31:0] xa, input logic [31:0] xb);
    rd_a_en = ea; rd_b_en = eb; addr_a = aa; addr_b = ab;
    #1;
    n_vec++; if (mem_rdy !== 1'b1) begin n_err++; $display("FAIL %s accept_rdy got=%b exp=1", nm, mem_rdy); end
    @(negedge clk);
    rd_a_en = 1'b0; rd_b_en = 1'b0; addr_a = 16'h0001; addr_b = 16'h0002;
    n_vec++; if (mem_valid !== 1'b0 || mem_rdy !== 1'b0) begin n_err++; $display("FAIL %s t1 valid=%b rdy=%b exp 0/0", nm, mem_valid, mem_rdy); end
    @(negedge clk);
    n_vec++; if (mem_valid !== 1'b1 || mem_rdy !== 1'b0) begin n_err++; $display("FAIL %s t2 valid=%b rdy=%b exp 1/0", nm, mem_valid, mem_rdy); end
    n_vec++; if (data_a !== xa) begin n_err++; $display("FAIL %s data_a got=%h exp=%h", nm, data_a, xa); end
    n_vec++; if (data_b !== xb) begin n_err++; $display("FAIL %s data_b got=%h exp=%h", nm, data_b, xb); end
    @(negedge clk);
    n_vec++; if (mem_valid !== 1'b0 || mem_rdy !== 1'b1) begin n_err++; $display("FAIL %s t3 valid=%b rdy=%b exp 0/1", nm, mem_valid, mem_rdy); end
    $display("read %s a=%0d(en %b) b=%0d(en %b) -> data_a=%h data_b=%h", nm, aa, ea, ab, eb, data_a, data_b);
  endtask

  task automatic do_write(input string nm, input logic [15:0] ac, input logic [31:0] dc, input logic ea);
    wr_en = 1'b1; addr_c = ac; data_c = dc; rd_a_en = ea; addr_a = 16'd7;
    @(negedge clk);
    wr_en = 1'b0; rd_a_en = 1'b0; data_c = 32'hBAD0BAD0; addr_c = 16'd0;
    n_vec++; if (mem_valid !== 1'b1 || mem_rdy !== 1'b0) begin n_err++; $display("FAIL %s ack valid=%b rdy=%b exp 1/0", nm, mem_valid, mem_rdy); end
    @(negedge clk);
    n_vec++; if (mem_valid !== 1'b0 || mem_rdy !== 1'b1) begin n_err++; $display("FAIL %s after valid=%b rdy=%b exp 0/1", nm, mem_valid, mem_rdy); end
    $display("write %s addr=%0d data=%h", nm, ac, dc);
  endtask

  task automatic do_load(input logic [15:0] la, input logic [31:0] ld);
    load_en = 1'b1; load_addr = la; load_data = ld;
    #1;
    n_vec++; if (mem_rdy !== 1'b0) begin n_err++; $display("FAIL load_rdy got=%b exp=0", mem_rdy); end
    @(negedge clk);
    load_en = 1'b0; load_data = 32'h0;
    $display("load addr=%0d data=%h", la, ld);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (mem_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy_low got=%b exp=0", mem_rdy); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_rdy !== 1'b1 || mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_rel rdy=%b valid=%b exp 1/0", mem_rdy, mem_valid); end
    n_vec++; if (data_a !== 32'h0 || data_b !== 32'h0 || err_oob !== 1'b0) begin n_err++; $display("FAIL reset_out a=%h b=%h err=%b exp 0", data_a, data_b, err_oob); end
    $display("reset released rdy=%b", mem_rdy);
  endtask

  task automatic test_load_read();
    do_load(16'd3, 32'hDEADBEEF);
    do_load(16'd7, 32'h00000010);
    do_read("ab", 1'b1, 1'b1, 16'd3, 16'd7, 32'hDEADBEEF, 32'h00000010);
  endtask

  task automatic test_write_read();
    do_write("w5", 16'd5, 32'h12345678, 1'b0);
    do_read("a5", 1'b1, 1'b0, 16'd5, 16'd0, 32'h12345678, 32'h00000010);
  endtask

  task automatic test_single_port();
    do_read("a_only", 1'b1, 1'b0, 16'd3, 16'd5, 32'hDEADBEEF, 32'h00000010);
    do_read("b_only", 1'b0, 1'b1, 16'd5, 16'd5, 32'hDEADBEEF, 32'h12345678);
  endtask

  task automatic test_write_drops_read();
    do_write("wr_rd", 16'd9, 32'hA5A5A5A5, 1'b1);
    n_vec++; if (data_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd data_a got=%h exp=deadbeef", data_a); end
    do_read("a9", 1'b1, 1'b0, 16'd9, 16'd0, 32'hA5A5A5A5, 32'h12345678);
  endtask

  task automatic test_oob();
    rd_a_en = 1'b1; addr_a = 16'd40;
    n_vec++; if (err_oob !== 1'b0) begin n_err++; $display("FAIL oob_pre err got=%b exp=0", err_oob); end
    @(negedge clk);
    rd_a_en = 1'b0;
    n_vec++; if (err_oob !== 1'b1) begin n_err++; $display("FAIL oob_set err got=%b exp=1", err_oob); end
    @(negedge clk);
    n_vec++; if (mem_valid !== 1'b1 || data_a !== 32'h0) begin n_err++; $display("FAIL oob_read valid=%b data_a=%h exp 1/0", mem_valid, data_a); end
    @(negedge clk);
    do_write("w33", 16'd33, 32'hFFFFFFFF, 1'b0);
    do_load(16'd35, 32'h00000001);
    do_read("alias", 1'b1, 1'b1, 16'd1, 16'd3, 32'h0, 32'hDEADBEEF);
    n_vec++; if (err_oob !== 1'b1) begin n_err++; $display("FAIL oob_sticky err got=%b exp=1", err_oob); end
  endtask

  task automatic test_reset_mid_read();
    rd_a_en = 1'b1; addr_a = 16'd3;
    @(negedge clk);
    rd_a_en = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_valid !== 1'b0 || mem_rdy !== 1'b0) begin n_err++; $display("FAIL rst_mid valid=%b rdy=%b exp 0/0", mem_valid, mem_rdy); end
    n_vec++; if (data_a !== 32'h0 || data_b !== 32'h0 || err_oob !== 1'b0) begin n_err++; $display("FAIL rst_mid_out a=%h b=%h err=%b exp 0", data_a, data_b, err_oob); end
    @(negedge clk);
    n_vec++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_late valid got=%b exp=0", mem_valid); end
    rst = 1'b1;
    #1;
    n_vec++; if (mem_rdy !== 1'b1) begin n_err++; $display("FAIL rst_mid_rel rdy got=%b exp=1", mem_rdy); end
    @(negedge clk);
    do_read("cleared", 1'b1, 1'b1, 16'd3, 16'd5, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b0; rd_a_en = 1'b0; rd_b_en = 1'b0; wr_en = 1'b0;
    addr_a = '0; addr_b = '0; addr_c = '0; data_c = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    @(negedge clk);
    test_reset();
    test_load_read();
    test_write_read();
    test_single_port();
    test_write_drops_read();
    test_oob();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Any breach of the handshake invariant is counted as a miscompare.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_vec++;
      if (mem_rdy === 1'b1 && mem_valid === 1'b1) begin
        n_err++;
        $display("FAIL rdy_valid_overlap rdy=%b valid=%b exp not both 1", mem_rdy, mem_valid);
      end
    end
  end

endmodule
